// File: rtl/parallel_to_serial_if.sv
// Handshake bundle for parallel_to_serial: word input side and serial output side.
// The out_last signal exists only when PTS_LAST_EN is defined.
interface parallel_to_serial_if #(
  parameter int P_WIDTH = 2
);
  logic [P_WIDTH-1:0] parallel;
  logic               in_valid;
  logic               in_ready;
  logic               serial;
  logic               out_valid;
  logic               out_ready;
`ifdef PTS_LAST_EN
  logic               out_last;
`endif

  modport master (
    output parallel,
    output in_valid,
    output out_ready,
    input  in_ready,
    input  serial,
`ifdef PTS_LAST_EN
    input  out_last,
`endif
    input  out_valid
  );

  modport slave (
    input  parallel,
    input  in_valid,
    input  out_ready,
    output in_ready,
    output serial,
`ifdef PTS_LAST_EN
    output out_last,
`endif
    output out_valid
  );
endinterface

// File: rtl/parallel_to_serial.sv
// Word-to-bit serializer, LSB first, with a one-word holding register for gapless streaming.
// Optional feature macro PTS_LAST_EN adds a registered out_last flag on bit P_WIDTH-1.
//
// state | meaning
// IDLE  | no word in flight, out_valid=0, serial=0
// SHIFT | shift_reg[0] is on serial, out_valid=1
module parallel_to_serial #(
  parameter int P_WIDTH = 2
) (
  input logic               clk,
  input logic               rst,
  parallel_to_serial_if.slave bus
);
  localparam int COUNTER_WIDTH = $clog2(P_WIDTH);
  localparam logic [COUNTER_WIDTH-1:0] LAST_IDX = COUNTER_WIDTH'(P_WIDTH - 1);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t                   state;
  logic [P_WIDTH-1:0]       shift_reg;
  logic [P_WIDTH-1:0]       hold_reg;
  logic [COUNTER_WIDTH-1:0] bit_cnt;
  logic [COUNTER_WIDTH-1:0] cnt_inc;
  logic                     hold_vld;
  logic                     accept;
  logic                     consume;
  logic                     last_bit;

  assign bus.in_ready  = ~hold_vld;
  assign accept        = bus.in_valid & ~hold_vld;
  assign consume       = (state == SHIFT) & bus.out_ready;
  assign last_bit      = (bit_cnt == LAST_IDX);
  assign cnt_inc       = bit_cnt + 1'b1;
  // shift_reg is cleared on entry to IDLE, so its LSB is the registered serial bit
  assign bus.serial    = shift_reg[0];
  assign bus.out_valid = (state == SHIFT);

`ifdef PTS_LAST_EN
  logic last_q;
  assign bus.out_last = last_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      bit_cnt   <= '0;
      hold_vld  <= 1'b0;
`ifdef PTS_LAST_EN
      last_q    <= 1'b0;
`endif
    end else if (state == IDLE) begin
      if (accept) begin
        state     <= SHIFT;
        shift_reg <= bus.parallel;
        bit_cnt   <= '0;
`ifdef PTS_LAST_EN
        last_q    <= 1'b0;
`endif
      end
    end else if (consume && last_bit) begin
      bit_cnt <= '0;
`ifdef PTS_LAST_EN
      last_q  <= 1'b0;
`endif
      if (hold_vld) begin
        shift_reg <= hold_reg;
        hold_vld  <= 1'b0;
      end else if (accept) begin
        shift_reg <= bus.parallel;
      end else begin
        state     <= IDLE;
        shift_reg <= '0;
      end
    end else begin
      if (consume) begin
        shift_reg <= {1'b0, shift_reg[P_WIDTH-1:1]};
        bit_cnt   <= cnt_inc;
`ifdef PTS_LAST_EN
        last_q    <= (cnt_inc == LAST_IDX);
`endif
      end
      // mid-word accepts park in the holding register
      if (accept) begin
        hold_reg <= bus.parallel;
        hold_vld <= 1'b1;
      end
    end
  end
endmodule
